// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath slice width and the add/sub sequencer state codes.
package alu_pkg;

    localparam int SLICE_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/seq_addsub32_rca8.sv
// 8-bit ripple-carry adder slice, reused every cycle by the sequential add/sub unit.
module RCA8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    always_comb begin
        logic c;
        sum_o = '0;
        c     = cin_i;
        for (int unsigned i = 0; i < 8; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c;
            c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        cout_o = c;
    end

endmodule

// File: rtl/seq_addsub32.sv
// Low-area add/subtract: one byte slice per cycle, LSB first, with a registered carry
// chaining the slices; valid/ready handshake on operands and on the result.
module seq_addsub32
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    logic [1:0]                      state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [NSLICE-1:0][SLICE_W-1:0]  a_q, a_d;
    logic [NSLICE-1:0][SLICE_W-1:0]  b_q, b_d;
    logic [NSLICE-1:0][SLICE_W-1:0]  res_q, res_d;
    logic                            carry_q, carry_d;
    logic                            cout_q, cout_d;
    logic                            ovf_q, ovf_d;

    logic [SLICE_W-1:0] sl_sum;
    logic               sl_cout;

    RCA8 u_slice (
        .a_i    (a_q[idx_q]),
        .b_i    (b_q[idx_q]),
        .cin_i  (carry_q),
        .sum_o  (sl_sum),
        .cout_o (sl_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract as A + ~B + 1: invert B once here, seed the carry with sub.
                    a_d     = op_a;
                    b_d     = op_b ^ {WIDTH{sub}};
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[idx_q] = sl_sum;
                carry_d      = sl_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = sl_cout;
                    ovf_d   = (a_q[NSLICE-1][SLICE_W-1] ~^ b_q[NSLICE-1][SLICE_W-1]) &&
                              (sl_sum[SLICE_W-1] != a_q[NSLICE-1][SLICE_W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_addsub32.sv
// Scoreboard bench for seq_addsub32: directed vectors with hand-computed results.
module tb_seq_addsub32;

    localparam int NSLICE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        cout;
    logic        ovf;

    seq_addsub32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic        c;
        logic        o;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        o;
        int          acc;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: held low
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
    endtask

    // Sole driver of out_ready.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: latency on each rising out_valid, data compare on each result handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov && sbq.size() > 0)
                chk("latency", 32'(cyc - sbq[0].acc), 32'(NSLICE));
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got 0x%08h expected none", result);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("result", result, e.r);
                    chk("cout", 32'(cout), 32'(e.c));
                    chk("ovf", 32'(ovf), 32'(e.o));
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] r, input logic c, input logic o, input bit track);
        int w;
        w = 0;
        do begin
            @(posedge clk);
            #1;
            w++;
        end while (!in_ready && w < 200);
        if (!in_ready) begin
            timeout("in_ready");
            return;
        end
        op_a = a;
        op_b = b;
        sub = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        if (track) sbq.push_back('{r, c, o, cyc});
        in_valid = 1'b0;
        // Scramble operands: they must have been captured at the accept edge.
        op_a = ~a;
        op_b = b ^ 32'h5A5A_A5A5;
        sub = ~s;
        chk("busy_after_accept", 32'(in_ready), 32'd0);
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] r, input logic c, input logic o);
        vecs.push_back('{a, b, s, r, c, o});
    endtask

    task automatic wait_drain(input string nm);
        int w;
        w = 0;
        while ((sbq.size() > 0 || out_valid) && w < 2000) begin
            @(posedge clk);
            w++;
        end
        if (sbq.size() > 0 || out_valid) timeout(nm);
    endtask

    initial begin
        add_vec(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        add_vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        add_vec(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        add_vec(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        add_vec(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        add_vec(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        add_vec(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        add_vec(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        add_vec(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        add_vec(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        add_vec(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        add_vec(32'h1000_0000, 32'h0000_0001, 1'b1, 32'h0FFF_FFFF, 1'b1, 1'b0);
        add_vec(32'hDEAD_BEEF, 32'h0102_0304, 1'b0, 32'hDFAF_C1F3, 1'b0, 1'b0);
        add_vec(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        add_vec(32'h0000_0003, 32'h0000_0003, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        add_vec(32'h1234_5678, 32'h8765_4321, 1'b1, 32'h8ACF_1357, 1'b0, 1'b1);
        add_vec(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);

        // Reset state
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        #20;
        rst_n = 1'b1;

        // Directed vectors, consumer always ready
        foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].c, vecs[i].o, 1'b1);
        wait_drain("drain_directed");

        // Backpressure: result held while out_ready low; in_valid during DONE ignored
        ready_mode = 2;
        repeat (2) @(posedge clk);
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b1);
        begin
            int w;
            w = 0;
            while (!out_valid && w < 50) begin
                @(posedge clk);
                #1;
                w++;
            end
            if (!out_valid) timeout("bp_out_valid");
        end
        op_a = 32'h0000_0001;
        op_b = 32'h0000_0001;
        sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", result, 32'h2345_6789);
        end
        in_valid = 1'b0;
        ready_mode = 0;
        begin
            int w;
            w = 0;
            while (out_valid && w < 20) begin
                @(posedge clk);
                #2;
                w++;
            end
            if (out_valid) timeout("bp_release");
        end
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #2;
        chk("bp_no_phantom", 32'(out_valid), 32'd0);
        chk("bp_still_idle", 32'(in_ready), 32'd1);

        // Reset two cycles into RUN aborts the operation
        issue(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_result", result, 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
        wait_drain("drain_after_abort");

        // Same vectors with a randomly stalling consumer
        ready_mode = 1;
        for (int rep = 0; rep < 3; rep++)
            foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].c, vecs[i].o, 1'b1);
        ready_mode = 0;
        wait_drain("drain_random_ready");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
